// File: rtl/data_ram_resp.sv
// Single-port data RAM with a registered load response for the CPU.
// A zeroing sweep runs after every reset before any access is served.
module data_ram_resp #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_ena,
    input  logic        data_ram_wea,
    input  logic [31:0] addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        misalign_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    // state | meaning
    // CLEAR | zeroing one word per cycle from index 0; CPU requests ignored
    // READY | serving aligned CPU reads and writes
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   idx;
    logic                aligned;
    logic                acc_wr;
    logic                acc_rd;
    logic                bad_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_widx;
    logic [31:0]         mem_wval;
    logic [31:0]         mem [DEPTH];
    logic                unused_addr_hi;

    // Upper address bits alias; they are deliberately dropped.
    assign idx            = addr[ADDR_W+1:2];
    assign aligned        = (addr[1:0] == 2'b00);
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        bad_req   = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = clr_ptr;
        mem_wval  = 32'h0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (&clr_ptr) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (data_ram_ena) begin
                    if (aligned) begin
                        acc_wr = data_ram_wea;
                        acc_rd = !data_ram_wea;
                    end else begin
                        bad_req = 1'b1;
                    end
                end
                mem_we   = acc_wr;
                mem_widx = idx;
                mem_wval = mem_wdata;
            end
            default: begin
                state_nxt = CLEAR;
                busy      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
        end else begin
            clr_ptr <= '0;
        end
    end

    // Storage has no reset; the sweep is what makes its contents known.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wval;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 32'h0;
        end else if (acc_wr) begin
            mem_rdata <= mem_wdata;
        end else if (acc_rd) begin
            mem_rdata <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (bad_req) begin
            misalign_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (acc_rd && (rd_cnt != 32'hFFFF_FFFF)) begin
                rd_cnt <= rd_cnt + 32'h1;
            end
            if (acc_wr && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'h1;
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp (ADDR_W=4) with a reference model
// and a queue of expected load responses.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ram_ena = 1'b0;
    logic        data_ram_wea = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        misalign_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [16];
    logic [31:0] m_last;
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    logic        m_mis;
    logic [31:0] exp_q [$];

    data_ram_resp #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ram_ena (data_ram_ena),
        .data_ram_wea (data_ram_wea),
        .addr         (addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .misalign_err (misalign_err),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
        m_last = 32'h0;
        m_rd   = 32'h0;
        m_wr   = 32'h0;
        m_mis  = 1'b0;
        exp_q.delete();
    endtask

    // Assert reset between edges and confirm the outputs respond without a clock.
    task automatic apply_reset();
        rst = 1'b1;
        data_ram_ena = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_mis", {31'h0, misalign_err}, 32'h0);
        chk("rst_rd_cnt", rd_cnt, 32'h0);
        chk("rst_wr_cnt", wr_cnt, 32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
    endtask

    // Release reset and count busy cycles; optionally drive a write at sweep cycle inj.
    task automatic release_and_sweep(input int inj);
        int cycles = 0;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cycles + 1 == inj) begin
                data_ram_ena = 1'b1;
                data_ram_wea = 1'b1;
                addr         = 32'h0000_0000;
                mem_wdata    = 32'hBAD0_BAD0;
            end
            @(posedge clk);
            #1;
            cycles++;
            data_ram_ena = 1'b0;
            if (!busy) break;
            chk("sweep_rdata", mem_rdata, 32'h0);
        end
        chk("busy_len", cycles, 32'd16);
        chk("sweep_wr_cnt", wr_cnt, 32'h0);
    endtask

    task automatic req(input logic ena, input logic wea, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp;
        @(negedge clk);
        data_ram_ena = ena;
        data_ram_wea = wea;
        addr         = a;
        mem_wdata    = wd;
        if (ena && a[1:0] == 2'b00) begin
            if (wea) begin
                m_mem[a[5:2]] = wd;
                m_last = wd;
                m_wr++;
            end else begin
                m_last = m_mem[a[5:2]];
                m_rd++;
            end
        end else if (ena) begin
            m_mis = 1'b1;
        end
        exp_q.push_back(m_last);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk("rdata", mem_rdata, exp);
        chk("rd_cnt", rd_cnt, m_rd);
        chk("wr_cnt", wr_cnt, m_wr);
        chk("misalign", {31'h0, misalign_err}, {31'h0, m_mis});
    endtask

    initial begin
        apply_reset();
        release_and_sweep(0);
        req(1, 0, 32'h0000_003C, 32'h0);          // freshly cleared word
        req(1, 1, 32'h0000_0008, 32'hDEAD_BEEF);
        req(1, 0, 32'h0000_0008, 32'h0);          // back-to-back write then read
        req(0, 0, 32'h0000_0008, 32'h0);          // idle holds data
        req(1, 1, 32'h0000_0040, 32'h1234_5678);  // aliases index 0
        req(1, 0, 32'h0000_0000, 32'h0);
        req(1, 0, 32'hFFFF_FF80, 32'h0);          // high bits ignored, index 0
        req(1, 1, 32'h0000_0006, 32'h0000_0001);  // misaligned write
        req(1, 0, 32'h0000_0004, 32'h0);
        req(1, 0, 32'h0000_0003, 32'h0);          // misaligned read
        req(1, 1, 32'h0000_0024, 32'hA5A5_0F0F);
        req(0, 1, 32'h0000_0024, 32'hFFFF_FFFF);  // ena low, no write
        req(1, 0, 32'h0000_0024, 32'h0);
        req(1, 1, 32'h0000_003C, 32'hCAFE_F00D);

        // Write during the sweep must be lost; contents cleared again.
        apply_reset();
        release_and_sweep(3);
        req(1, 0, 32'h0000_0000, 32'h0);
        req(1, 0, 32'h0000_003C, 32'h0);
        req(1, 0, 32'h0000_0024, 32'h0);
        req(1, 1, 32'h0000_0010, 32'h0BAD_F00D);
        req(1, 1, 32'h0000_0011, 32'h0);

        // Reset pulsed at sweep cycle 8 restarts the whole sweep.
        apply_reset();
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        apply_reset();
        release_and_sweep(0);
        chk("post_mis", {31'h0, misalign_err}, 32'h0);
        chk("post_rd_cnt", rd_cnt, 32'h0);
        req(1, 0, 32'h0000_0010, 32'h0);
        req(1, 0, 32'h0000_003C, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
